// File: rtl/branch_predictor_if.sv
// Fetch-lookup, EX-resolve and statistics signals of the branch predictor.
// master = pipeline side, slave = predictor.
interface branch_predictor_if;
   logic [31:0] lookup_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        flush_all;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   modport master (
      output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, flush_all,
      input  pred_taken, pred_target, mispredict, redirect_pc,
             branch_count, mispredict_count
   );

   modport slave (
      input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, flush_all,
      output pred_taken, pred_target, mispredict, redirect_pc,
             branch_count, mispredict_count
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters. Combinational lookup for IF,
// trained by EX at the clock edge; flags mispredictions with the correct redirect PC.
module branch_predictor #(
   parameter int ENTRIES  = 16,
   parameter int TAG_BITS = 8,
   parameter int CNT_BITS = 2
) (
   input  logic               clk,
   input  logic               rst,
   branch_predictor_if.slave  bp
);

   localparam int IDX = $clog2(ENTRIES);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
   localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1 << (CNT_BITS-1));

   typedef struct packed {
      logic                valid;
      logic [TAG_BITS-1:0] tag;
      logic [31:0]         target;
      logic [CNT_BITS-1:0] cnt;
   } entry_t;

   entry_t      tbl_q [ENTRIES];
   entry_t      tbl_d [ENTRIES];
   logic [31:0] branch_count_q, branch_count_d;
   logic [31:0] mispredict_count_q, mispredict_count_d;

   logic [IDX-1:0]      lk_idx, up_idx;
   logic [TAG_BITS-1:0] lk_tag, up_tag;
   entry_t              lk_e, up_e;
   logic                lk_hit, up_hit;
   logic                misp;

   assign lk_idx = bp.lookup_pc[IDX+1:2];
   assign lk_tag = bp.lookup_pc[IDX+TAG_BITS+1:IDX+2];
   assign up_idx = bp.upd_pc[IDX+1:2];
   assign up_tag = bp.upd_pc[IDX+TAG_BITS+1:IDX+2];

   // Lookup reads registered state only, so a same-cycle write is not visible.
   always_comb begin
      lk_e           = tbl_q[lk_idx];
      lk_hit         = lk_e.valid && (lk_e.tag == lk_tag);
      bp.pred_taken  = lk_hit && lk_e.cnt[CNT_BITS-1];
      bp.pred_target = bp.pred_taken ? lk_e.target : bp.lookup_pc + 32'd4;
   end

   always_comb begin
      misp = bp.upd_valid &&
             ((bp.upd_taken != bp.upd_pred_taken) ||
              (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
      bp.mispredict  = misp;
      bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
   end

   always_comb begin
      up_e   = tbl_q[up_idx];
      up_hit = up_e.valid && (up_e.tag == up_tag);
      tbl_d  = tbl_q;
      if (bp.flush_all) begin
         for (int i = 0; i < ENTRIES; i++) tbl_d[i].valid = 1'b0;
      end else if (bp.upd_valid) begin
         if (up_hit) begin
            if (bp.upd_taken) begin
               if (up_e.cnt != CNT_MAX) tbl_d[up_idx].cnt = up_e.cnt + CNT_BITS'(1);
               tbl_d[up_idx].target = bp.upd_target;
            end else if (up_e.cnt != '0) begin
               tbl_d[up_idx].cnt = up_e.cnt - CNT_BITS'(1);
            end
         end else if (bp.upd_taken) begin
            // Allocation overwrites whatever aliased into this slot.
            tbl_d[up_idx].valid  = 1'b1;
            tbl_d[up_idx].tag    = up_tag;
            tbl_d[up_idx].target = bp.upd_target;
            tbl_d[up_idx].cnt    = CNT_WEAK;
         end
      end
   end

   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (bp.upd_valid) branch_count_d = branch_count_q + 32'd1;
      if (misp) mispredict_count_d = mispredict_count_q + 32'd1;
   end

   assign bp.branch_count     = branch_count_q;
   assign bp.mispredict_count = mispredict_count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         tbl_q              <= tbl_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with an abstract BTB model checked every cycle,
// plus hand-computed literal expectations.
module tb_branch_predictor;
   localparam int ENTRIES  = 16;
   localparam int TAG_BITS = 8;
   localparam int CNT_BITS = 2;
   localparam int unsigned CMAX  = (1 << CNT_BITS) - 1;
   localparam int unsigned CWEAK = 1 << (CNT_BITS - 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_predictor_if bif ();

   branch_predictor #(.ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CNT_BITS(CNT_BITS)) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bif.slave)
   );

   int total = 0;
   int bad   = 0;

   bit          m_val [ENTRIES];
   int unsigned m_tag [ENTRIES];
   int unsigned m_tgt [ENTRIES];
   int unsigned m_cnt [ENTRIES];
   int unsigned m_bc, m_mc;

   function automatic int unsigned f_idx(int unsigned pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned f_tag(int unsigned pc);
      return (pc / (4 * ENTRIES)) % (1 << TAG_BITS);
   endfunction

   function automatic bit m_hit(int unsigned pc);
      return m_val[f_idx(pc)] && (m_tag[f_idx(pc)] == f_tag(pc));
   endfunction

   // Taken when the counter sits in the upper half of its range.
   function automatic bit m_ptaken(int unsigned pc);
      return m_hit(pc) && (m_cnt[f_idx(pc)] >= CWEAK);
   endfunction

   function automatic int unsigned m_ptarget(int unsigned pc);
      return m_ptaken(pc) ? m_tgt[f_idx(pc)] : pc + 4;
   endfunction

   function automatic bit m_misp();
      return bif.upd_valid && ((bif.upd_taken != bif.upd_pred_taken) ||
             (bif.upd_taken && (bif.upd_target != bif.upd_pred_target)));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
      end
      m_bc = 0; m_mc = 0;
   endtask

   task automatic model_update();
      int unsigned pc, ix;
      pc = bif.upd_pc;
      ix = f_idx(pc);
      if (m_misp()) m_mc++;
      if (bif.upd_valid) m_bc++;
      if (bif.flush_all) begin
         for (int i = 0; i < ENTRIES; i++) m_val[i] = 0;
      end else if (bif.upd_valid) begin
         if (m_hit(pc)) begin
            if (bif.upd_taken) begin
               if (m_cnt[ix] < CMAX) m_cnt[ix]++;
               m_tgt[ix] = bif.upd_target;
            end else if (m_cnt[ix] > 0) begin
               m_cnt[ix]--;
            end
         end else if (bif.upd_taken) begin
            m_val[ix] = 1; m_tag[ix] = f_tag(pc); m_tgt[ix] = bif.upd_target; m_cnt[ix] = CWEAK;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("pred_taken", {31'b0, bif.pred_taken}, {31'b0, m_ptaken(bif.lookup_pc)});
      chk("pred_target", bif.pred_target, m_ptarget(bif.lookup_pc));
      chk("mispredict", {31'b0, bif.mispredict}, {31'b0, m_misp()});
      if (m_misp())
         chk("redirect_pc", bif.redirect_pc, bif.upd_taken ? bif.upd_target : bif.upd_pc + 32'd4);
      chk("branch_count", bif.branch_count, m_bc);
      chk("mispredict_count", bif.mispredict_count, m_mc);
   endtask

   task automatic settle();
      @(negedge clk);
      check_all();
   endtask

   task automatic edge_step();
      @(posedge clk);
      if (rst) model_update();
      #1;
   endtask

   task automatic idle(input logic [31:0] lpc);
      bif.lookup_pc = lpc; bif.upd_valid = 0; bif.upd_taken = 0; bif.flush_all = 0;
      bif.upd_pc = 0; bif.upd_target = 0; bif.upd_pred_taken = 0; bif.upd_pred_target = 0;
   endtask

   // Update with the prediction fetch would have made for that PC.
   task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic [31:0] lpc);
      bif.lookup_pc = lpc; bif.flush_all = 0;
      bif.upd_valid = 1; bif.upd_pc = pc; bif.upd_taken = tk; bif.upd_target = tgt;
      bif.upd_pred_taken = m_ptaken(pc); bif.upd_pred_target = m_ptarget(pc);
   endtask

   task automatic lookup_lit(input logic [31:0] lpc, input logic tk, input logic [31:0] tgt,
                             input string nm);
      idle(lpc);
      settle();
      chk({nm, "_taken"}, {31'b0, bif.pred_taken}, {31'b0, tk});
      chk({nm, "_target"}, bif.pred_target, tgt);
      edge_step();
   endtask

   initial begin
      rst = 1'b0;
      idle(32'h40);
      model_reset();
      #2;
      check_all();
      chk("rst_taken", {31'b0, bif.pred_taken}, 32'd0);
      chk("rst_target", bif.pred_target, 32'h44);
      chk("rst_bc", bif.branch_count, 32'd0);
      chk("rst_mc", bif.mispredict_count, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      edge_step();

      // First taken branch allocates; same-cycle lookup sees old contents.
      set_upd(32'h100, 1, 32'h80, 32'h100);
      settle();
      chk("first_misp", {31'b0, bif.mispredict}, 32'd1);
      chk("first_redirect", bif.redirect_pc, 32'h80);
      chk("no_bypass", {31'b0, bif.pred_taken}, 32'd0);
      edge_step();
      chk("first_mc", bif.mispredict_count, 32'd1);
      lookup_lit(32'h100, 1, 32'h80, "alloc");

      // Train down to zero without underflow.
      for (int i = 0; i < 3; i++) begin
         set_upd(32'h100, 0, 32'h0, 32'h100);
         settle();
         if (i == 0) begin
            chk("nt_misp", {31'b0, bif.mispredict}, 32'd1);
            chk("nt_redirect", bif.redirect_pc, 32'h104);
         end
         edge_step();
      end
      chk("nt_mc", bif.mispredict_count, 32'd2);
      chk("nt_bc", bif.branch_count, 32'd4);
      lookup_lit(32'h100, 0, 32'h104, "decayed");

      // Alias into index 0 with a different tag.
      lookup_lit(32'h140, 0, 32'h144, "alias_pre");
      set_upd(32'h140, 1, 32'h200, 32'h140);
      settle(); edge_step();
      lookup_lit(32'h140, 1, 32'h200, "alias_new");
      lookup_lit(32'h100, 0, 32'h104, "alias_evicted");

      // Taken with wrong target.
      set_upd(32'h100, 1, 32'h80, 32'h100);
      settle(); edge_step();
      set_upd(32'h100, 1, 32'h90, 32'h100);
      settle();
      chk("tgt_misp", {31'b0, bif.mispredict}, 32'd1);
      chk("tgt_redirect", bif.redirect_pc, 32'h90);
      edge_step();
      lookup_lit(32'h100, 1, 32'h90, "tgt_rewritten");

      // Saturation: two more taken keep cnt at max, one not-taken still predicts taken.
      for (int i = 0; i < 3; i++) begin
         set_upd(32'h100, (i < 2), 32'h90, 32'h100 + 32'(i * 4));
         settle(); edge_step();
      end
      lookup_lit(32'h100, 1, 32'h90, "saturated");

      // 32-bit wrap of PC+4, then allocate at the top of memory.
      lookup_lit(32'hFFFF_FFFC, 0, 32'h0, "wrap_miss");
      set_upd(32'hFFFF_FFFC, 1, 32'h10, 32'hFFFF_FFFC);
      settle(); edge_step();
      lookup_lit(32'hFFFF_FFFC, 1, 32'h10, "wrap_hit");

      // Flush beats a same-cycle allocation but the branch still counts.
      set_upd(32'h300, 1, 32'h400, 32'h300);
      bif.flush_all = 1;
      settle(); edge_step();
      chk("flush_bc", bif.branch_count, 32'd12);
      lookup_lit(32'h300, 0, 32'h304, "flush_300");
      lookup_lit(32'h140, 0, 32'h144, "flush_140");
      for (int i = 0; i < ENTRIES; i++) begin
         idle(32'h100 + 32'(i * 4));
         settle(); edge_step();
      end

      // Asynchronous reset in the middle of an update cycle.
      set_upd(32'h100, 1, 32'h80, 32'h100);
      settle(); edge_step();
      set_upd(32'h180, 1, 32'h500, 32'h100);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      chk("arst_taken", {31'b0, bif.pred_taken}, 32'd0);
      chk("arst_target", bif.pred_target, 32'h104);
      chk("arst_bc", bif.branch_count, 32'd0);
      chk("arst_mc", bif.mispredict_count, 32'd0);
      settle(); edge_step();
      idle(32'h180);
      @(negedge clk);
      rst = 1'b1;
      edge_step();
      lookup_lit(32'h180, 0, 32'h184, "arst_dropped");
      lookup_lit(32'h100, 0, 32'h104, "arst_cleared");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
